// File: rtl/ppi_port_readback.sv
// ----------------------------------------------------------------------------
// ppi_port_readback
//
// Port-input capture and CPU readback unit for the 8255A PPI core.
//
// Each input port runs either in mode 0 (direct: a one-cycle registered copy
// of the pins) or in mode 1 (strobed latch). In mode 1 the strobe is
// synchronised, and the data is latched on the strobe's falling edge. The
// port then raises an IBF/INTR handshake and records an overrun if another
// strobe arrives before the CPU has read the buffer.
//
// The CPU issues one-cycle read requests. Each read returns one of these
// sources, one clock later, together with a one-cycle bus drive enable:
//   - the raw port pins,
//   - a latched buffer,
//   - the status word,
//   - zero, with a select-error pulse, for an out-of-range select.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   port_in    in   port pins, port i = [i*DATA_W +: DATA_W]
//   port_mode  in   per port: 0 = mode 0 direct, 1 = mode 1 strobed
//   stb_n      in   per port strobe, active low, asynchronous to clk
//   inte       in   per port interrupt enable
//   rd_req     in   one-cycle CPU read request
//   rd_sel     in   read source select, sampled with rd_req
//   dout       out  registered read data, holds between reads
//   dout_oe    out  bus drive enable, high only in the cycle dout is fresh
//   sel_err    out  one-cycle pulse for an out-of-range rd_sel
//   ibf        out  per port input buffer full
//   intr       out  per port interrupt request
//
// Read select map
//   2*i          raw port_in[i]
//   2*i+1        buffer of port i; a mode-1 read clears ibf/intr/ovr
//   2*NUM_PORTS  status word: bits [4i+3:4i] = {ovr, intr, ibf, inte}
//   above        out of range: dout = 0, sel_err = 1
// ----------------------------------------------------------------------------
module ppi_port_readback #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 2,
    parameter int SEL_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS*DATA_W-1:0] port_in,
    input  logic [NUM_PORTS-1:0]        port_mode,
    input  logic [NUM_PORTS-1:0]        stb_n,
    input  logic [NUM_PORTS-1:0]        inte,
    input  logic                        rd_req,
    input  logic [SEL_W-1:0]            rd_sel,
    output logic [DATA_W-1:0]           dout,
    output logic                        dout_oe,
    output logic                        sel_err,
    output logic [NUM_PORTS-1:0]        ibf,
    output logic [NUM_PORTS-1:0]        intr
);

    // The status word sits just past the last per-port select pair.
    localparam logic [SEL_W-1:0] STATUS_SEL = SEL_W'(2 * NUM_PORTS);

    // ------------------------------------------------------------------------
    // Parameter sanity: the status word needs 4 bits per port, and the select
    // must be able to encode every source plus the status word.
    // ------------------------------------------------------------------------
    if (DATA_W < 4 * NUM_PORTS || (2 ** SEL_W) <= 2 * NUM_PORTS) begin : g_bad_params
        $error("ppi_port_readback: need DATA_W >= 4*NUM_PORTS and 2**SEL_W > 2*NUM_PORTS");
    end

    // ------------------------------------------------------------------------
    // Strobe synchronisation and edge detection
    // stb_s1/stb_s2 form the two-flop synchroniser; stb_d delays the
    // synchronised value by one more cycle for edge detection. All three
    // reset to the idle (high) level, so leaving reset with the strobe
    // inactive produces no spurious edge.
    // ------------------------------------------------------------------------
    logic [NUM_PORTS-1:0] stb_s1;
    logic [NUM_PORTS-1:0] stb_s2;
    logic [NUM_PORTS-1:0] stb_d;
    logic [NUM_PORTS-1:0] fall;
    logic [NUM_PORTS-1:0] rise;

    // NOTE: clocked state uses non-blocking (<=) assignments so every flop
    // samples the pre-edge values; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1 <= '1;
            stb_s2 <= '1;
            stb_d  <= '1;
        end else begin
            stb_s1 <= stb_n;
            stb_s2 <= stb_s1;
            stb_d  <= stb_s2;
        end
    end

    assign fall = stb_d & ~stb_s2;
    assign rise = ~stb_d & stb_s2;

    // ------------------------------------------------------------------------
    // Buffer-read detect: a mode-1 buffer read clears the handshake flags.
    // In mode 0 the flags are already held at zero, so the read has no
    // side effects there.
    // ------------------------------------------------------------------------
    logic [NUM_PORTS-1:0] buf_rd;

    // NOTE: every signal assigned in always_comb gets a default first, so a
    // path that skips an assignment cannot infer a latch.
    always_comb begin
        buf_rd = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            buf_rd[i] = rd_req && (rd_sel == SEL_W'(2 * i + 1)) && port_mode[i];
        end
    end

    // ------------------------------------------------------------------------
    // Per-port capture and handshake state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]    buf_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] ovr;

    // NOTE: the buffer array is reset explicitly. It is only a few registers
    // (not a RAM), and a read straight after reset must return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                buf_q[i] <= '0;
            end
            ibf  <= '0;
            intr <= '0;
            ovr  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!port_mode[i]) begin
                    // Mode 0 is a plain registered copy. Dropping to mode 0
                    // also clears any handshake left over from mode 1.
                    buf_q[i] <= port_in[i*DATA_W +: DATA_W];
                    ibf[i]   <= 1'b0;
                    intr[i]  <= 1'b0;
                    ovr[i]   <= 1'b0;
                end else begin
                    // Latch only into an empty buffer, or into one whose old
                    // contents are being read out in this same cycle.
                    if (fall[i] && (!ibf[i] || buf_rd[i])) begin
                        buf_q[i] <= port_in[i*DATA_W +: DATA_W];
                    end

                    // When a strobe and a read collide, the set wins: the
                    // newly latched data makes the buffer full again.
                    if (fall[i]) begin
                        ibf[i] <= 1'b1;
                    end else if (buf_rd[i]) begin
                        ibf[i] <= 1'b0;
                    end

                    // Overrun: a strobe arrives while the buffer is still
                    // full and is not being read out.
                    if (buf_rd[i]) begin
                        ovr[i] <= 1'b0;
                    end else if (fall[i] && ibf[i]) begin
                        ovr[i] <= 1'b1;
                    end

                    // The interrupt is raised when the strobe is released
                    // with data waiting. Clearing inte drops intr at once.
                    if (!inte[i] || buf_rd[i]) begin
                        intr[i] <= 1'b0;
                    end else if (rise[i] && ibf[i]) begin
                        intr[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status word and read mux
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    always_comb begin
        status = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            status[4*i +: 4] = {ovr[i], intr[i], ibf[i], inte[i]};
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_sel == SEL_W'(2 * i)) begin
                rd_data = port_in[i*DATA_W +: DATA_W];
            end
            if (rd_sel == SEL_W'(2 * i + 1)) begin
                rd_data = buf_q[i];
            end
        end
        if (rd_sel == STATUS_SEL) begin
            rd_data = status;
        end
        if (rd_sel > STATUS_SEL) begin
            rd_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read response. dout keeps the last value read; the enable
    // and the error pulse last only for the response cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout    <= '0;
            dout_oe <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            dout_oe <= rd_req;
            sel_err <= rd_req && rd_err;
            if (rd_req) begin
                dout <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ppi_port_readback.sv
// ----------------------------------------------------------------------------
// tb_ppi_port_readback
//
// Self-checking bench for ppi_port_readback with the default parameters
// (two 8-bit ports, 3-bit select). Each read pushes its expected data and
// error bit onto a queue. A monitor pops one entry for each cycle in which
// dout_oe is high. Flag checks are made inline in the scenario tasks.
// ----------------------------------------------------------------------------
module tb_ppi_port_readback;

    localparam int DATA_W    = 8;
    localparam int NUM_PORTS = 2;
    localparam int SEL_W     = 3;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_PORTS*DATA_W-1:0] port_in;
    logic [NUM_PORTS-1:0]        port_mode;
    logic [NUM_PORTS-1:0]        stb_n;
    logic [NUM_PORTS-1:0]        inte;
    logic                        rd_req;
    logic [SEL_W-1:0]            rd_sel;
    logic [DATA_W-1:0]           dout;
    logic                        dout_oe;
    logic                        sel_err;
    logic [NUM_PORTS-1:0]        ibf;
    logic [NUM_PORTS-1:0]        intr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t sb[$];

    ppi_port_readback #(
        .DATA_W   (DATA_W),
        .NUM_PORTS(NUM_PORTS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port_in  (port_in),
        .port_mode(port_mode),
        .stb_n    (stb_n),
        .inte     (inte),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .dout     (dout),
        .dout_oe  (dout_oe),
        .sel_err  (sel_err),
        .ibf      (ibf),
        .intr     (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response monitor: every enabled cycle must match the oldest queued read.
    always @(negedge clk) begin
        if (rst_n && dout_oe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_oe: dout_oe=1 dout=%h with no read outstanding", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (dout !== e.data || sel_err !== e.err) begin
                    errors++;
                    $display("FAIL read_resp: got dout=%h sel_err=%b, expected dout=%h sel_err=%b",
                             dout, sel_err, e.data, e.err);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic rd(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data, input logic err);
        exp_t e;
        @(negedge clk);
        rd_req = 1'b1;
        rd_sel = sel;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic rd_end();
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Full strobe: data is set up, stb_n is low for 4 clocks, then 4 clocks
    // of settling after release.
    task automatic strobe(input int p, input logic [DATA_W-1:0] data);
        @(negedge clk);
        port_in[p*DATA_W +: DATA_W] = data;
        stb_n[p] = 1'b0;
        repeat (4) @(negedge clk);
        stb_n[p] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_flags(input string name, input logic [NUM_PORTS-1:0] e_ibf,
                                input logic [NUM_PORTS-1:0] e_intr);
        checks++;
        if (ibf !== e_ibf || intr !== e_intr) begin
            errors++;
            $display("FAIL %s: ibf=%b intr=%b, expected ibf=%b intr=%b", name, ibf, intr, e_ibf, e_intr);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        // Outputs while held in reset.
        repeat (2) @(negedge clk);
        checks++;
        if ({dout, dout_oe, sel_err, ibf, intr} !== '0) begin
            errors++;
            $display("FAIL reset_state: dout=%h oe=%b err=%b ibf=%b intr=%b, expected all 0",
                     dout, dout_oe, sel_err, ibf, intr);
        end
        rst_n = 1'b1;

        // Build up flags and dout, then reset between clock edges.
        inte[0] = 1'b1;
        strobe(0, 8'h77);
        expect_flags("pre_reset_flags", 2'b01, 2'b01);
        rd(0, 8'h77, 1'b0);
        rd_end();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_oe, sel_err, ibf, intr} !== '0) begin
            errors++;
            $display("FAIL async_reset: dout=%h oe=%b err=%b ibf=%b intr=%b, expected all 0",
                     dout, dout_oe, sel_err, ibf, intr);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        inte[0] = 1'b0;
        // The buffer and status must also come back cleared.
        rd(1, 8'h00, 1'b0);
        rd(4, 8'h00, 1'b0);
        rd_end();
    endtask

    task automatic test_mode1();
        inte[0] = 1'b1;
        @(negedge clk);
        port_in[7:0] = 8'hA5;
        stb_n[0] = 1'b0;
        repeat (4) @(negedge clk);
        expect_flags("mode1_ibf_set", 2'b01, 2'b00);
        stb_n[0] = 1'b1;
        repeat (4) @(negedge clk);
        expect_flags("mode1_intr_set", 2'b01, 2'b01);
        rd(4, 8'h07, 1'b0);
        rd(1, 8'hA5, 1'b0);
        rd_end();
        expect_flags("mode1_read_clears", 2'b00, 2'b00);
        @(negedge clk);
        checks++;
        if (dout_oe !== 1'b0 || dout !== 8'hA5) begin
            errors++;
            $display("FAIL oe_one_cycle: dout_oe=%b dout=%h, expected 0 and held A5", dout_oe, dout);
        end
        inte[0] = 1'b0;
    endtask

    task automatic test_overrun();
        strobe(0, 8'h11);
        strobe(0, 8'h22);
        expect_flags("overrun_flags", 2'b01, 2'b00);
        rd(4, 8'h0A, 1'b0);
        rd(1, 8'h11, 1'b0);
        rd(4, 8'h00, 1'b0);
        rd_end();
    endtask

    task automatic test_collision();
        strobe(1, 8'hC3);
        expect_flags("collision_prefill", 2'b10, 2'b00);
        // Time the read so that it is sampled in the fall-event cycle,
        // three clocks after the strobe is driven low.
        @(negedge clk);
        port_in[15:8] = 8'h3C;
        stb_n[1] = 1'b0;
        @(negedge clk);
        rd(3, 8'hC3, 1'b0);
        rd_end();
        expect_flags("collision_ibf_kept", 2'b10, 2'b00);
        repeat (3) @(negedge clk);
        stb_n[1] = 1'b1;
        repeat (4) @(negedge clk);
        // ovr is clear and ibf is set for port B; nothing is pending on port A.
        rd(4, 8'h20, 1'b0);
        rd(3, 8'h3C, 1'b0);
        rd_end();
        expect_flags("collision_drained", 2'b00, 2'b00);
    endtask

    task automatic test_mode0();
        strobe(0, 8'h44);
        expect_flags("mode0_prefill", 2'b01, 2'b00);
        @(negedge clk);
        port_mode[0] = 1'b0;
        port_in[7:0] = 8'h5A;
        @(negedge clk);
        expect_flags("mode_change_clears", 2'b00, 2'b00);
        rd(0, 8'h5A, 1'b0);
        rd(1, 8'h5A, 1'b0);
        rd_end();
        strobe(0, 8'h5A);
        expect_flags("mode0_ignores_stb", 2'b00, 2'b00);
        rd(4, 8'h00, 1'b0);
        rd_end();
    endtask

    task automatic test_sel_err();
        inte[1] = 1'b1;
        strobe(1, 8'h99);
        expect_flags("selerr_prefill", 2'b10, 2'b10);
        rd(4, 8'h70, 1'b0);
        rd(5, 8'h00, 1'b1);
        rd(7, 8'h00, 1'b1);
        rd(2, 8'h99, 1'b0);
        rd_end();
        @(negedge clk);
        expect_flags("selerr_no_side_effect", 2'b10, 2'b10);
        checks++;
        if (sel_err !== 1'b0 || dout_oe !== 1'b0) begin
            errors++;
            $display("FAIL selerr_pulse_end: sel_err=%b dout_oe=%b, expected 0 0", sel_err, dout_oe);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        port_in   = '0;
        port_mode = 2'b11;
        stb_n     = 2'b11;
        inte      = 2'b00;
        rd_req    = 1'b0;
        rd_sel    = '0;

        test_reset();
        test_mode1();
        test_overrun();
        test_collision();
        test_mode0();
        test_sel_err();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: %0d reads never answered, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
